legv8_instr_fetch: RTL and testbench
====================================

LEGV8_INSTR_FETCH -- requirements
Module: legv8_instr_fetch

Interface
REQ-001 Parameter: RESET_PC, default 64'h0, address of first fetch after reset.
REQ-002 Parameter: MEM_W, default 32, instruction word width.
REQ-003 clock  in  1  single clock; all state changes on its rising edge.
REQ-004 reset  in  1  asynchronous, active-low reset.
REQ-005 mem_req  out  1  instruction-memory read request.
REQ-006 mem_addr  out  64  byte address of the requested word.
REQ-007 mem_ack  in  1  one-cycle acknowledge; mem_rdata is valid in the same cycle.
REQ-008 mem_rdata  in  32  returned instruction word.
REQ-009 instruction  out  32  instruction presented to the control unit.
REQ-010 instr_valid  out  1  instruction is valid.
REQ-011 instr_ready  in  1  control unit consumes the instruction.
REQ-012 pc  out  64  address of the presented or pending instruction.
REQ-013 pc_sel  in  2  next-PC select: 00 = PC+4, 01 = PC+(constant<<2), 10 = reg_target, 11 = PC+4.
REQ-014 constant  in  64  signed word offset from the control unit.
REQ-015 reg_target  in  64  register branch target (BR).
REQ-016 flush  in  1  asynchronous-to-flow redirect request.
REQ-017 flush_target  in  64  redirect address used with flush.

Function
REQ-018 The block SHALL implement the states IDLE, FETCH, HOLD and DRAIN.
REQ-019 IDLE SHALL go to FETCH on the first clock edge after reset deasserts.
REQ-020 In FETCH, mem_req SHALL be 1 and mem_addr SHALL equal pc; both SHALL stay stable until mem_ack.
REQ-021 On mem_ack in FETCH: instruction <= mem_rdata, instr_valid <= 1, next state HOLD; the latency from ack to instr_valid SHALL be one cycle.
REQ-022 In HOLD, instruction and pc SHALL stay stable while instr_valid=1 and instr_ready=0.
REQ-023 A handshake (instr_valid & instr_ready) SHALL clear instr_valid, update pc per pc_sel (sampled that cycle), and go to FETCH.
REQ-024 Next-PC arithmetic SHALL be modulo 2^64 (wrap, no saturation); reg_target and flush_target SHALL have bits [1:0] forced to 0.
REQ-025 flush in FETCH with mem_ack=1 SHALL discard mem_rdata, set pc <= flush_target, and stay in FETCH.
REQ-026 flush in FETCH with mem_ack=0 SHALL set pc <= flush_target and go to DRAIN.
REQ-027 DRAIN SHALL keep mem_req=1 and mem_addr at the old address until mem_ack, discard the data, then go to FETCH.
REQ-028 flush in HOLD SHALL clear instr_valid, set pc <= flush_target and go to FETCH.
REQ-029 flush SHALL take priority over a simultaneous handshake.
REQ-030 A further flush during DRAIN SHALL only overwrite pc.
REQ-031 instr_valid SHALL never be 1 in FETCH, DRAIN or IDLE.
REQ-032 The block SHALL keep at most one memory request outstanding.

Reset
REQ-033 Reset assertion SHALL immediately force: state=IDLE, pc=RESET_PC, instruction=0, instr_valid=0, mem_req=0, mem_addr=RESET_PC.
REQ-034 Reset mid-request SHALL abandon the request without waiting for mem_ack; a late mem_ack after reset SHALL be ignored while in IDLE.

Structure
REQ-035 Shared package legv8_pkg SHALL hold the pc_sel encodings, the fetch state enum, and the INSTR_W=32 and ADDR_W=64 constants.
REQ-036 Next-PC selection and adder SHALL live in the combinational sub-module legv8_next_pc.

Verification
REQ-037 The bench SHALL cover these directed scenarios:
- Reset release, memory acks in the next cycle with 32'h8B1F0040 -> mem_addr=0; instruction=32'h8B1F0040 and instr_valid=1 one cycle after ack.
- Handshake with pc_sel=01, constant=-2, pc=0x10 -> next mem_addr=0x08; with pc_sel=10, reg_target=0x103 -> mem_addr=0x100.
- instr_ready held 0 for 5 cycles -> instruction and pc are unchanged, with no new mem_req.
- flush (target 0x200) while a request is outstanding, ack 3 cycles later -> the acked data is dropped, then mem_addr=0x200 is fetched, and no instr_valid appears in between.
- flush and handshake in the same cycle with pc_sel=00 -> pc=flush_target, not PC+4.
- pc=0xFFFF_FFFF_FFFF_FFFC with pc_sel=00 -> wraps to 0x0; reset asserted mid-FETCH -> mem_req=0 immediately and pc=RESET_PC.

Source files
------------

// File: rtl/legv8_pkg.sv
// Shared types and constants for the LEGv8 instruction-fetch slice.
package legv8_pkg;

    localparam int INSTR_W = 32;
    localparam int ADDR_W  = 64;

    typedef enum logic [1:0] {
        PC_SEL_SEQ     = 2'b00,
        PC_SEL_BRANCH  = 2'b01,
        PC_SEL_REG     = 2'b10,
        PC_SEL_SEQ_ALT = 2'b11
    } pc_sel_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_FETCH = 2'b01,
        ST_HOLD  = 2'b10,
        ST_DRAIN = 2'b11
    } fetch_state_e;

endpackage

// File: rtl/legv8_instr_fetch_if.sv
// Fetch-unit bus: instruction-memory request side, control-unit side and redirect inputs.
interface legv8_instr_fetch_if #(
    parameter int MEM_W = legv8_pkg::INSTR_W
);
    import legv8_pkg::*;

    // Memory: mem_req/mem_addr hold until the single-cycle mem_ack. Control unit:
    // a transfer happens on any rising edge with instr_valid & instr_ready both high.
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_ack;
    logic [MEM_W-1:0]  mem_rdata;
    logic [MEM_W-1:0]  instruction;
    logic              instr_valid;
    logic              instr_ready;
    logic [ADDR_W-1:0] pc;
    logic [1:0]        pc_sel;
    logic [ADDR_W-1:0] constant;
    logic [ADDR_W-1:0] reg_target;
    logic              flush;
    logic [ADDR_W-1:0] flush_target;

    modport master (
        output mem_req, mem_addr, instruction, instr_valid, pc,
        input  mem_ack, mem_rdata, instr_ready, pc_sel, constant,
               reg_target, flush, flush_target
    );

    modport slave (
        input  mem_req, mem_addr, instruction, instr_valid, pc,
        output mem_ack, mem_rdata, instr_ready, pc_sel, constant,
               reg_target, flush, flush_target
    );

endinterface

// File: rtl/legv8_next_pc.sv
// Combinational next-PC selection: sequential, PC-relative branch or register target.
module legv8_next_pc
    import legv8_pkg::*;
(
    input  logic [ADDR_W-1:0] i_pc,
    input  logic [1:0]        i_pc_sel,
    input  logic [ADDR_W-1:0] i_constant,
    input  logic [ADDR_W-1:0] i_reg_target,
    output logic [ADDR_W-1:0] o_next_pc
);

    logic [ADDR_W-1:0] w_branch_off;
    logic [ADDR_W-1:0] w_reg_aligned;

    // Word offset to byte offset; the shift drops the top two bits so the add wraps mod 2^64.
    assign w_branch_off  = i_constant << 2;
    assign w_reg_aligned = i_reg_target & ~ADDR_W'(3);

    always_comb begin
        o_next_pc = i_pc + ADDR_W'(4);
        case (pc_sel_e'(i_pc_sel))
            PC_SEL_BRANCH: o_next_pc = i_pc + w_branch_off;
            PC_SEL_REG:    o_next_pc = w_reg_aligned;
            default:       o_next_pc = i_pc + ADDR_W'(4);
        endcase
    end

endmodule

// File: rtl/legv8_instr_fetch.sv
// Single-outstanding instruction fetch with hold-until-consumed output and flush/drain redirect.
module legv8_instr_fetch
    import legv8_pkg::*;
#(
    parameter logic [63:0] RESET_PC = 64'h0,
    parameter int          MEM_W    = 32
) (
    input  logic                clock,
    input  logic                reset,
    legv8_instr_fetch_if.master bus,
    output fetch_state_e        o_state
);

    fetch_state_e      r_state, w_state_nxt;
    logic [ADDR_W-1:0] r_pc, w_pc_nxt;
    logic [ADDR_W-1:0] r_drain_addr, w_drain_addr_nxt;
    logic [MEM_W-1:0]  r_instruction, w_instruction_nxt;
    logic              r_instr_valid, w_instr_valid_nxt;
    logic [ADDR_W-1:0] w_next_pc;
    logic [ADDR_W-1:0] w_flush_pc;

    assign w_flush_pc = bus.flush_target & ~ADDR_W'(3);

    legv8_next_pc u_next_pc (
        .i_pc         (r_pc),
        .i_pc_sel     (bus.pc_sel),
        .i_constant   (bus.constant),
        .i_reg_target (bus.reg_target),
        .o_next_pc    (w_next_pc)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state       <= ST_IDLE;
            r_pc          <= RESET_PC;
            r_drain_addr  <= RESET_PC;
            r_instruction <= '0;
            r_instr_valid <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_pc          <= w_pc_nxt;
            r_drain_addr  <= w_drain_addr_nxt;
            r_instruction <= w_instruction_nxt;
            r_instr_valid <= w_instr_valid_nxt;
        end
    end

    always_comb begin
        w_state_nxt       = r_state;
        w_pc_nxt          = r_pc;
        w_drain_addr_nxt  = r_drain_addr;
        w_instruction_nxt = r_instruction;
        w_instr_valid_nxt = r_instr_valid;
        case (r_state)
            ST_IDLE: begin
                w_state_nxt = ST_FETCH;
            end
            ST_FETCH: begin
                if (bus.flush) begin
                    w_pc_nxt = w_flush_pc;
                    // Unacked request must still complete at the old address before refetching.
                    if (!bus.mem_ack) begin
                        w_drain_addr_nxt = r_pc;
                        w_state_nxt      = ST_DRAIN;
                    end
                end else if (bus.mem_ack) begin
                    w_instruction_nxt = bus.mem_rdata;
                    w_instr_valid_nxt = 1'b1;
                    w_state_nxt       = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (bus.flush) begin
                    w_instr_valid_nxt = 1'b0;
                    w_pc_nxt          = w_flush_pc;
                    w_state_nxt       = ST_FETCH;
                end else if (bus.instr_ready) begin
                    w_instr_valid_nxt = 1'b0;
                    w_pc_nxt          = w_next_pc;
                    w_state_nxt       = ST_FETCH;
                end
            end
            ST_DRAIN: begin
                if (bus.flush) begin
                    w_pc_nxt = w_flush_pc;
                end
                if (bus.mem_ack) begin
                    w_state_nxt = ST_FETCH;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign bus.mem_req     = (r_state == ST_FETCH) || (r_state == ST_DRAIN);
    assign bus.mem_addr    = (r_state == ST_DRAIN) ? r_drain_addr : r_pc;
    assign bus.instruction = r_instruction;
    assign bus.instr_valid = r_instr_valid;
    assign bus.pc          = r_pc;
    assign o_state         = r_state;

endmodule

// File: tb/tb_legv8_instr_fetch.sv
// Directed self-checking bench for legv8_instr_fetch.
module tb_legv8_instr_fetch;
    import legv8_pkg::*;

    logic         clock = 1'b0;
    logic         reset = 1'b0;
    fetch_state_e state;
    int           checks   = 0;
    int           failures = 0;

    legv8_instr_fetch_if bus ();

    legv8_instr_fetch dut (
        .clock   (clock),
        .reset   (reset),
        .bus     (bus),
        .o_state (state)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic ack_word(input logic [31:0] d);
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = d;
        tick();
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = '0;
    endtask

    task automatic handshake(input logic [1:0] sel, input logic [63:0] c, input logic [63:0] rt);
        bus.instr_ready = 1'b1;
        bus.pc_sel      = sel;
        bus.constant    = c;
        bus.reg_target  = rt;
        tick();
        bus.instr_ready = 1'b0;
    endtask

    task automatic test_reset();
        bus.mem_ack = 0; bus.mem_rdata = '0; bus.instr_ready = 0; bus.pc_sel = 2'b00;
        bus.constant = '0; bus.reg_target = '0; bus.flush = 0; bus.flush_target = '0;
        @(negedge clock);
        @(negedge clock);
        if (state !== ST_IDLE) begin failures++; $display("FAIL rst_state actual=%0d required=%0d", state, ST_IDLE); end
        checks++;
        if (bus.pc !== 64'h0) begin failures++; $display("FAIL rst_pc actual=%h required=%h", bus.pc, 64'h0); end
        checks++;
        if (bus.instruction !== 32'h0) begin failures++; $display("FAIL rst_instr actual=%h required=%h", bus.instruction, 32'h0); end
        checks++;
        if (bus.instr_valid !== 1'b0) begin failures++; $display("FAIL rst_valid actual=%b required=0", bus.instr_valid); end
        checks++;
        if (bus.mem_req !== 1'b0) begin failures++; $display("FAIL rst_req actual=%b required=0", bus.mem_req); end
        checks++;
        reset = 1'b1;
        tick();
        if (state !== ST_FETCH) begin failures++; $display("FAIL first_fetch_state actual=%0d required=%0d", state, ST_FETCH); end
        checks++;
        if (bus.mem_req !== 1'b1 || bus.mem_addr !== 64'h0) begin
            failures++; $display("FAIL first_fetch_req actual=%b/%h required=1/%h", bus.mem_req, bus.mem_addr, 64'h0);
        end
        checks++;
        ack_word(32'h8B1F0040);
        if (bus.instr_valid !== 1'b1 || bus.instruction !== 32'h8B1F0040) begin
            failures++; $display("FAIL first_instr actual=%b/%h required=1/%h", bus.instr_valid, bus.instruction, 32'h8B1F0040);
        end
        checks++;
        if (bus.mem_req !== 1'b0) begin failures++; $display("FAIL hold_no_req actual=%b required=0", bus.mem_req); end
        checks++;
    endtask

    task automatic test_next_pc();
        handshake(2'b01, 64'd4, 64'h0);
        if (bus.mem_addr !== 64'h10 || bus.instr_valid !== 1'b0) begin
            failures++; $display("FAIL br_fwd actual=%h/%b required=%h/0", bus.mem_addr, bus.instr_valid, 64'h10);
        end
        checks++;
        ack_word(32'hA0000001);
        handshake(2'b01, -64'sd2, 64'h0);
        if (bus.mem_addr !== 64'h8 || bus.pc !== 64'h8) begin
            failures++; $display("FAIL br_back actual=%h/%h required=%h", bus.mem_addr, bus.pc, 64'h8);
        end
        checks++;
        ack_word(32'hA0000002);
        handshake(2'b10, 64'h0, 64'h103);
        if (bus.mem_addr !== 64'h100) begin failures++; $display("FAIL br_reg actual=%h required=%h", bus.mem_addr, 64'h100); end
        checks++;
        ack_word(32'hA0000003);
        handshake(2'b11, 64'h40, 64'h500);
        if (bus.mem_addr !== 64'h104) begin failures++; $display("FAIL sel11_seq actual=%h required=%h", bus.mem_addr, 64'h104); end
        checks++;
    endtask

    task automatic test_stall();
        ack_word(32'hD2800020);
        for (int i = 0; i < 5; i++) begin
            tick();
            if (bus.instruction !== 32'hD2800020 || bus.pc !== 64'h104 || bus.instr_valid !== 1'b1) begin
                failures++; $display("FAIL stall_hold cyc=%0d actual=%h/%h/%b required=%h/%h/1",
                                     i, bus.instruction, bus.pc, bus.instr_valid, 32'hD2800020, 64'h104);
            end
            checks++;
            if (bus.mem_req !== 1'b0) begin failures++; $display("FAIL stall_req cyc=%0d actual=%b required=0", i, bus.mem_req); end
            checks++;
        end
    endtask

    task automatic test_flush_drain();
        handshake(2'b00, 64'h0, 64'h0);
        if (bus.mem_addr !== 64'h108) begin failures++; $display("FAIL pre_flush_addr actual=%h required=%h", bus.mem_addr, 64'h108); end
        checks++;
        bus.flush = 1'b1; bus.flush_target = 64'h180;
        tick();
        bus.flush = 1'b0;
        if (state !== ST_DRAIN || bus.mem_req !== 1'b1 || bus.mem_addr !== 64'h108 || bus.pc !== 64'h180) begin
            failures++; $display("FAIL drain_enter actual=%0d/%b/%h/%h required=%0d/1/%h/%h",
                                 state, bus.mem_req, bus.mem_addr, bus.pc, ST_DRAIN, 64'h108, 64'h180);
        end
        checks++;
        bus.flush = 1'b1; bus.flush_target = 64'h200;
        tick();
        bus.flush = 1'b0;
        if (bus.pc !== 64'h200 || bus.mem_addr !== 64'h108 || bus.instr_valid !== 1'b0) begin
            failures++; $display("FAIL drain_reflush actual=%h/%h/%b required=%h/%h/0", bus.pc, bus.mem_addr, bus.instr_valid, 64'h200, 64'h108);
        end
        checks++;
        tick();
        if (state !== ST_DRAIN || bus.instr_valid !== 1'b0) begin
            failures++; $display("FAIL drain_wait actual=%0d/%b required=%0d/0", state, bus.instr_valid, ST_DRAIN);
        end
        checks++;
        ack_word(32'hDEADBEEF);
        if (state !== ST_FETCH || bus.mem_addr !== 64'h200 || bus.instr_valid !== 1'b0 || bus.instruction !== 32'hD2800020) begin
            failures++; $display("FAIL drain_drop actual=%0d/%h/%b/%h required=%0d/%h/0/%h",
                                 state, bus.mem_addr, bus.instr_valid, bus.instruction, ST_FETCH, 64'h200, 32'hD2800020);
        end
        checks++;
        ack_word(32'h11111111);
        if (bus.instr_valid !== 1'b1 || bus.instruction !== 32'h11111111 || bus.pc !== 64'h200) begin
            failures++; $display("FAIL post_drain_instr actual=%b/%h/%h required=1/%h/%h", bus.instr_valid, bus.instruction, bus.pc, 32'h11111111, 64'h200);
        end
        checks++;
    endtask

    task automatic test_flush_with_ack();
        handshake(2'b00, 64'h0, 64'h0);
        bus.flush = 1'b1; bus.flush_target = 64'h303;
        bus.mem_ack = 1'b1; bus.mem_rdata = 32'hBAD0BAD0;
        tick();
        bus.flush = 1'b0; bus.mem_ack = 1'b0;
        if (state !== ST_FETCH || bus.mem_addr !== 64'h300 || bus.instr_valid !== 1'b0 || bus.instruction !== 32'h11111111) begin
            failures++; $display("FAIL flush_ack actual=%0d/%h/%b/%h required=%0d/%h/0/%h",
                                 state, bus.mem_addr, bus.instr_valid, bus.instruction, ST_FETCH, 64'h300, 32'h11111111);
        end
        checks++;
        ack_word(32'h22222222);
        if (bus.instruction !== 32'h22222222 || bus.pc !== 64'h300) begin
            failures++; $display("FAIL flush_ack_refetch actual=%h/%h required=%h/%h", bus.instruction, bus.pc, 32'h22222222, 64'h300);
        end
        checks++;
    endtask

    task automatic test_flush_vs_handshake();
        bus.instr_ready = 1'b1; bus.pc_sel = 2'b00;
        bus.flush = 1'b1; bus.flush_target = 64'h400;
        tick();
        bus.instr_ready = 1'b0; bus.flush = 1'b0;
        if (bus.pc !== 64'h400 || bus.mem_addr !== 64'h400 || state !== ST_FETCH || bus.instr_valid !== 1'b0) begin
            failures++; $display("FAIL flush_priority actual=%h/%h/%0d/%b required=%h/%h/%0d/0",
                                 bus.pc, bus.mem_addr, state, bus.instr_valid, 64'h400, 64'h400, ST_FETCH);
        end
        checks++;
        ack_word(32'h33333333);
    endtask

    task automatic test_wrap();
        bus.flush = 1'b1; bus.flush_target = 64'hFFFF_FFFF_FFFF_FFFC;
        tick();
        bus.flush = 1'b0;
        if (state !== ST_FETCH || bus.pc !== 64'hFFFF_FFFF_FFFF_FFFC) begin
            failures++; $display("FAIL hold_flush actual=%0d/%h required=%0d/%h", state, bus.pc, ST_FETCH, 64'hFFFF_FFFF_FFFF_FFFC);
        end
        checks++;
        ack_word(32'h44444444);
        handshake(2'b00, 64'h0, 64'h0);
        if (bus.pc !== 64'h0 || bus.mem_addr !== 64'h0) begin
            failures++; $display("FAIL wrap_seq actual=%h/%h required=%h", bus.pc, bus.mem_addr, 64'h0);
        end
        checks++;
        ack_word(32'h44444445);
        handshake(2'b01, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0);
        if (bus.pc !== 64'hFFFF_FFFF_FFFF_FFFC) begin
            failures++; $display("FAIL wrap_branch actual=%h required=%h", bus.pc, 64'hFFFF_FFFF_FFFF_FFFC);
        end
        checks++;
    endtask

    task automatic test_reset_mid_fetch();
        if (bus.mem_req !== 1'b1) begin failures++; $display("FAIL pre_reset_req actual=%b required=1", bus.mem_req); end
        checks++;
        #2 reset = 1'b0;
        #1;
        if (bus.mem_req !== 1'b0 || state !== ST_IDLE) begin
            failures++; $display("FAIL async_reset actual=%b/%0d required=0/%0d", bus.mem_req, state, ST_IDLE);
        end
        checks++;
        if (bus.pc !== 64'h0 || bus.mem_addr !== 64'h0 || bus.instruction !== 32'h0 || bus.instr_valid !== 1'b0) begin
            failures++; $display("FAIL async_reset_regs actual=%h/%h/%h/%b required=0/0/0/0",
                                 bus.pc, bus.mem_addr, bus.instruction, bus.instr_valid);
        end
        checks++;
        @(negedge clock);
        bus.mem_ack = 1'b1; bus.mem_rdata = 32'h55555555;
        reset = 1'b1;
        tick();
        bus.mem_ack = 1'b0;
        if (state !== ST_FETCH || bus.instr_valid !== 1'b0 || bus.instruction !== 32'h0 || bus.mem_addr !== 64'h0) begin
            failures++; $display("FAIL late_ack_ignored actual=%0d/%b/%h/%h required=%0d/0/0/0",
                                 state, bus.instr_valid, bus.instruction, bus.mem_addr, ST_FETCH);
        end
        checks++;
        ack_word(32'h66666666);
        if (bus.instr_valid !== 1'b1 || bus.instruction !== 32'h66666666 || bus.pc !== 64'h0) begin
            failures++; $display("FAIL post_reset_fetch actual=%b/%h/%h required=1/%h/0", bus.instr_valid, bus.instruction, bus.pc, 32'h66666666);
        end
        checks++;
    endtask

    initial begin
        test_reset();
        test_next_pc();
        test_stall();
        test_flush_drain();
        test_flush_with_ack();
        test_flush_vs_handshake();
        test_wrap();
        test_reset_mid_fetch();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
